// File: rtl/riscv_pkg.sv
// riscv_pkg: immediate-format codes, loader FSM states and opcode constants shared across the core
package riscv_pkg;
  typedef enum logic [1:0] {I_TYPE = 2'b00, S_TYPE = 2'b01, B_TYPE = 2'b10, R_TYPE = 2'b11} imm_sel_e;
  typedef enum logic [1:0] {IDLE = 2'b00, LOAD = 2'b01, DONE = 2'b10} state_e;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
endpackage

// File: rtl/instr_pack.sv
// instr_pack: combinational field-to-word packing plus 12-bit immediate range flag
import riscv_pkg::*;
module instr_pack (
  input  logic [1:0]  imm_sel,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        range_err
);
  always_comb begin
    word = imm_sel == I_TYPE ? {imm[11:0], rs1, funct3, rd, opcode} :
           imm_sel == S_TYPE ? {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode} :
           imm_sel == B_TYPE ? {imm[11], imm[9:4], rs2, rs1, funct3, imm[3:0], imm[10], opcode} :
                               {funct7, rs2, rs1, funct3, rd, opcode};
    range_err = (imm_sel != R_TYPE) && (imm != {{20{imm[11]}}, imm[11:0]});
  end
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: packs field bundles into RV32 words and streams them to instruction memory
// Optional immediate range checker enabled by INSTR_ENCODER_RANGE_CHECK_EN.
import riscv_pkg::*;
module instr_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [1:0]        imm_sel,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] err_addr
);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d, word;
  logic wr_en_q, wr_en_d, range_err, accept;
  instr_pack u_pack (
    .imm_sel(imm_sel), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm), .word(word), .range_err(range_err)
  );
  assign accept = in_valid && state_q == LOAD && !start;
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    wr_en_d = accept;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (start) begin
      state_d = LOAD;
      addr_d = '0;
    end else if (accept) begin
      addr_d = addr_q + ADDR_W'(1);
      wr_addr_d = addr_q;
      wr_data_d = word;
      state_d = (in_last || &addr_q) ? DONE : LOAD;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      wr_en_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      wr_en_q <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end
  assign in_ready = state_q == LOAD;
  assign busy = state_q == LOAD;
  assign done = state_q == DONE;
  assign wr_en = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
  logic err_q, err_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;
  always_comb begin
    err_d = start ? 1'b0 : (err_q || (accept && range_err));
    err_addr_d = (accept && range_err && !err_q) ? addr_q : err_addr_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
      err_addr_q <= '0;
    end else begin
      err_q <= err_d;
      err_addr_q <= err_addr_d;
    end
  end
  assign err = err_q;
  assign err_addr = err_addr_q;
`else
  logic err_unused;
  assign err_unused = range_err;
  assign err = 1'b0;
  assign err_addr = '0;
`endif
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: table-driven vectors plus multi-cycle sequences for instr_encoder
import riscv_pkg::*;
module tb_instr_encoder;
  typedef struct {
    logic [1:0] sel; logic [6:0] op; logic [4:0] rd, rs1, rs2;
    logic [2:0] f3; logic [6:0] f7; logic [31:0] imm; logic [31:0] exp;
  } vec_t;
  logic clk = 0, rst = 1, start = 0, in_valid = 0, in_last = 0;
  logic [1:0] imm_sel = 0;
  logic [6:0] opcode = 0, funct7 = 0;
  logic [4:0] rd = 0, rs1 = 0, rs2 = 0;
  logic [2:0] funct3 = 0;
  logic [31:0] imm = 0;
  logic in_ready, wr_en, busy, done, err;
  logic [7:0] wr_addr, err_addr;
  logic [31:0] wr_data, s_wr_data;
  logic s_ready, s_wr_en, s_busy, s_done, s_err;
  logic [1:0] s_wr_addr, s_err_addr;
  int checks = 0, errors = 0;
  vec_t tbl [9];
  vec_t v;
  always #5 clk = ~clk;
  instr_encoder #(.ADDR_W(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .imm_sel(imm_sel), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
    .imm(imm), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done),
    .err(err), .err_addr(err_addr)
  );
  instr_encoder #(.ADDR_W(2)) u_small (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(s_ready), .in_last(in_last),
    .imm_sel(imm_sel), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
    .imm(imm), .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data), .busy(s_busy), .done(s_done),
    .err(s_err), .err_addr(s_err_addr)
  );
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic drive(input vec_t x);
    imm_sel = x.sel; opcode = x.op; rd = x.rd; rs1 = x.rs1; rs2 = x.rs2;
    funct3 = x.f3; funct7 = x.f7; imm = x.imm;
  endtask
  task automatic do_start();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask
  task automatic send(input vec_t x, input logic last);
    drive(x);
    in_valid = 1;
    in_last = last;
    @(negedge clk);
    in_valid = 0;
    in_last = 0;
  endtask
  initial begin
    int n;
    tbl[0] = '{I_TYPE, OP_IMM,    5'd1,  5'd0,  5'd0, 3'd0, 7'h00, 32'hFFFFFFFF, 32'hFFF00093};
    tbl[1] = '{S_TYPE, OP_STORE,  5'd0,  5'd1,  5'd2, 3'd2, 7'h00, 32'd8,        32'h0020A423};
    tbl[2] = '{B_TYPE, OP_BRANCH, 5'd0,  5'd1,  5'd2, 3'd0, 7'h00, 32'd4,        32'h00208463};
    tbl[3] = '{R_TYPE, OP_REG,    5'd3,  5'd1,  5'd2, 3'd0, 7'h00, 32'd0,        32'h002081B3};
    tbl[4] = '{R_TYPE, OP_REG,    5'd3,  5'd1,  5'd2, 3'd0, 7'h00, 32'hDEADBEEF, 32'h002081B3};
    tbl[5] = '{R_TYPE, OP_REG,    5'd3,  5'd1,  5'd2, 3'd0, 7'h20, 32'd0,        32'h402081B3};
    tbl[6] = '{B_TYPE, OP_BRANCH, 5'd0,  5'd1,  5'd2, 3'd0, 7'h00, 32'hFFFFFFFE, 32'hFE208EE3};
    tbl[7] = '{S_TYPE, OP_STORE,  5'd0,  5'd5,  5'd6, 3'd0, 7'h00, 32'hFFFFFFFF, 32'hFE628FA3};
    tbl[8] = '{I_TYPE, OP_LOAD,   5'd31, 5'd31, 5'd0, 3'd7, 7'h00, 32'h000007FF, 32'h7FFFFF83};
    repeat (2) @(negedge clk);
    rst = 0;
    chk("reset in_ready", {31'd0, in_ready}, 0);
    chk("reset wr_en", {31'd0, wr_en}, 0);
    chk("reset wr_addr", {24'd0, wr_addr}, 0);
    chk("reset wr_data", wr_data, 0);
    chk("reset busy", {31'd0, busy}, 0);
    chk("reset done", {31'd0, done}, 0);
    chk("reset err", {31'd0, err}, 0);
    chk("reset err_addr", {24'd0, err_addr}, 0);
    do_start();
    chk("busy after start", {31'd0, busy}, 1);
    chk("ready after start", {31'd0, in_ready}, 1);
    for (int i = 0; i < 9; i++) begin
      send(tbl[i], 0);
      chk($sformatf("vec%0d wr_en", i), {31'd0, wr_en}, 1);
      chk($sformatf("vec%0d wr_addr", i), {24'd0, wr_addr}, i);
      chk($sformatf("vec%0d wr_data", i), wr_data, tbl[i].exp);
    end
    @(negedge clk);
    chk("wr_en single pulse", {31'd0, wr_en}, 0);
    chk("no err on valid imms", {31'd0, err}, 0);
    do_start();
    for (int i = 0; i < 5; i++) send(tbl[1], 0);
    v = '{I_TYPE, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2048, 32'h80000093};
    send(v, 0);
    chk("range word 2048", wr_data, 32'h80000093);
    chk("range addr", {24'd0, wr_addr}, 5);
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    chk("range err set", {31'd0, err}, 1);
    chk("range err_addr", {24'd0, err_addr}, 5);
`else
    chk("range err off", {31'd0, err}, 0);
    chk("range err_addr off", {24'd0, err_addr}, 0);
`endif
    v.imm = 32'd4096;
    send(v, 0);
    chk("range word 4096", wr_data, 32'h00000093);
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    chk("err_addr first only", {24'd0, err_addr}, 5);
`else
    chk("err_addr off", {24'd0, err_addr}, 0);
`endif
    drive(tbl[0]);
    start = 1;
    in_valid = 1;
    @(negedge clk);
    start = 0;
    in_valid = 0;
    chk("start beats valid", {31'd0, wr_en}, 0);
    chk("start clears err", {31'd0, err}, 0);
    send(tbl[0], 1);
    chk("last wr_en", {31'd0, wr_en}, 1);
    chk("last addr restart", {24'd0, wr_addr}, 0);
    chk("last done", {31'd0, done}, 1);
    chk("last ready low", {31'd0, in_ready}, 0);
    chk("last busy low", {31'd0, busy}, 0);
    do_start();
    drive(tbl[3]);
    in_valid = 1;
    n = 0;
    repeat (7) begin
      @(negedge clk);
      if (s_wr_en) begin
        chk($sformatf("small addr%0d", n), {30'd0, s_wr_addr}, n);
        n++;
      end
    end
    in_valid = 0;
    chk("small write count", n, 4);
    chk("small done", {31'd0, s_done}, 1);
    chk("small ready low", {31'd0, s_ready}, 0);
    do_start();
    drive(tbl[0]);
    in_valid = 1;
    repeat (2) @(negedge clk);
    chk("pre-reset wr_addr", {24'd0, wr_addr}, 1);
    rst = 1;
    @(negedge clk);
    chk("rst wr_en", {31'd0, wr_en}, 0);
    chk("rst wr_addr", {24'd0, wr_addr}, 0);
    chk("rst wr_data", wr_data, 0);
    chk("rst in_ready", {31'd0, in_ready}, 0);
    chk("rst busy", {31'd0, busy}, 0);
    chk("rst done", {31'd0, done}, 0);
    rst = 0;
    repeat (2) begin
      @(negedge clk);
      chk("idle no write", {31'd0, wr_en}, 0);
    end
    do_start();
    @(negedge clk);
    in_valid = 0;
    chk("reload wr_en", {31'd0, wr_en}, 1);
    chk("reload addr 0", {24'd0, wr_addr}, 0);
    chk("reload data", wr_data, 32'hFFF00093);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
